cache_lru_ctrl: RTL and testbench
=================================

// Module: cache_lru_ctrl
// PURPOSE
// - Controller for the fully associative, LRU-ordered cache; sits directly upstream of en_shift_reg.
// - Drives the shift register's per-word enables and D input; reads back its packed Q. Entry 0 is MRU, entry LENGTH-1 is LRU.
// - Serves CPU read/write requests: hits are answered from the entries, misses and all writes go to memory (write-through, write-allocate).
// PARAMETERS
// - LENGTH  8   number of cache entries (must match the shift register's LENGTH)
// - ADDR_W  16  address width
// - DATA_W  8   data word width
// - ENTRY_W     localparam = 1+ADDR_W+DATA_W; entry = {empty, tag[ADDR_W], data[DATA_W]}
// PORTS
// - clk        in   1                 clock, all state updates on posedge
// - rst        in   1                 reset, synchronous, active-high
// - req_valid  in   1                 CPU request valid
// - req_ready  out  1                 controller can accept a request
// - req_we     in   1                 1 = write, 0 = read
// - req_addr   in   ADDR_W            request address
// - req_wdata  in   DATA_W            write data
// - resp_valid out  1                 one-cycle response pulse
// - resp_rdata out  DATA_W            read data, valid with resp_valid (read requests only)
// - resp_hit   out  1                 request hit in cache, valid with resp_valid
// - mem_req    out  1                 memory access request, held until mem_ack
// - mem_we     out  1                 memory write
// - mem_addr   out  ADDR_W            memory address
// - mem_wdata  out  DATA_W            memory write data
// - mem_ack    in   1                 memory done; mem_rdata valid in same cycle
// - mem_rdata  in   DATA_W            memory read data
// - sr_en      out  LENGTH            per-entry enables to shift register
// - sr_d       out  ENTRY_W           shift register D input (lands in entry 0)
// - sr_q       in   LENGTH*ENTRY_W    packed entries; entry i at [ENTRY_W*i +: ENTRY_W]
// BEHAVIOUR
// - States: IDLE, CHECK, MEM_RD, MEM_WR. Reset: state=IDLE, req_ready=1, resp_valid=0, mem_req=0, mem_we=0, sr_en=0.
// - All-ones entry (shift register reset value) has empty=1; empty entries never match.
// - IDLE: req_ready=1; on req_valid, latch we/addr/wdata -> CHECK. req_ready=0 in all other states.
// - CHECK: compare latched addr with tag of every non-empty entry; hit index k (lowest index if several).
//   - Read hit: resp_valid=1, resp_hit=1, resp_rdata=entry k data; sr_en[j]=1 for j<=k, sr_d=entry k; -> IDLE.
//   - Read miss: -> MEM_RD. Write (hit or miss): -> MEM_WR.
// - MEM_RD: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack: sr_en=all ones, sr_d={0,addr,mem_rdata},
//   resp_valid=1, resp_hit=0, resp_rdata=mem_rdata; -> IDLE. LRU entry is evicted.
// - MEM_WR: mem_req=1, mem_we=1, mem_addr/mem_wdata=latched. On mem_ack: hit at k -> sr_en[j]=1 for j<=k;
//   miss -> sr_en=all ones; sr_d={0,addr,wdata}; resp_valid=1, resp_hit=hit recorded in CHECK; -> IDLE.
// - sr_en is 0 in every cycle not listed above, and 0 while rst=1.
// - Latency: hit = resp_valid in cycle after acceptance; miss/write = resp_valid in the mem_ack cycle.
// - mem_addr/mem_wdata/mem_we stable while mem_req=1; mem_ack outside MEM_RD/MEM_WR is ignored.
// - rst mid-operation: next edge returns to IDLE, mem_req drops, pending request discarded, no response.
// - Tags unique at all times (only CHECK misses insert).
// TESTING
// - Reset, read 0x0010, mem_ack 3 cycles after mem_req with 0xAB -> mem_req high 3 cycles, resp_rdata=0xAB, hit=0, sr_en=0xFF, sr_d={0,0x0010,0xAB}.
// - Read 0x0010 again -> no mem_req, resp_valid cycle after accept, rdata=0xAB, hit=1, sr_en=0x01.
// - Misses on 0x0100..0x0107, then read 0x0100 -> hit at index 7, sr_en=0xFF; then read 0x0108 -> miss evicts 0x0101.
// - Write 0x0010=0x5C after it is cached -> mem write with 0x5C, promote sr_en per hit index, resp_hit=1; next read 0x0010 -> 0x5C, no mem_req.
// - Read 0xFFFF right after reset -> miss (empty entries never match), mem_req issued.
// - rst during MEM_RD wait -> mem_req=0 and req_ready=1 next cycle, no resp_valid; re-read same address misses.

Source files
------------

// File: rtl/cache_lru_ctrl.sv
// cache_lru_ctrl: request controller for a fully associative, LRU-ordered cache
// whose entries live in an external enable-per-word shift register
// (entry 0 = MRU, entry LENGTH-1 = LRU). Read hits are served from the entries.
// Read misses fetch from memory and insert at MRU. All writes go through to
// memory; a write hit promotes the entry and a write miss allocates it.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_*             CPU request (valid/ready handshake; we, addr, wdata)
//   resp_*            one-cycle response pulse with read data and hit flag
//   mem_*             memory request (held until mem_ack) and read data return
//   sr_en, sr_d       per-entry shift enables and MRU insert value
//   sr_q              packed shift register contents, entry i at [ENTRY_W*i +: ENTRY_W]
module cache_lru_ctrl #(
  parameter int unsigned LENGTH = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  output logic                        resp_valid,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        resp_hit,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [LENGTH-1:0]           sr_en,
  output logic [1+ADDR_W+DATA_W-1:0]  sr_d,
  input  logic [LENGTH*(1+ADDR_W+DATA_W)-1:0] sr_q
);

  localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned IDX_W   = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                hit_q, hit_d;
  logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;

  logic                lookup_hit;
  logic [IDX_W-1:0]    lookup_idx;
  logic [ENTRY_W-1:0]  lookup_entry;
  logic [IDX_W-1:0]    mask_idx;
  logic [LENGTH-1:0]   promote_mask;

  // State and latched request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
    end
  end

  // Tag lookup; descending scan so the lowest matching index wins.
  // The empty bit (MSB) excludes the all-ones reset entries.
  always_comb begin
    lookup_hit   = 1'b0;
    lookup_idx   = '0;
    lookup_entry = '0;
    for (int i = int'(LENGTH) - 1; i >= 0; i--) begin
      if (!sr_q[ENTRY_W*i + ENTRY_W - 1] &&
          (sr_q[ENTRY_W*i + DATA_W +: ADDR_W] == addr_q)) begin
        lookup_hit   = 1'b1;
        lookup_idx   = IDX_W'(i);
        lookup_entry = sr_q[ENTRY_W*i +: ENTRY_W];
      end
    end
  end

  // Promotion enables: shift entries 0..k so entry k is overwritten from above
  always_comb begin
    mask_idx     = (state_q == CHECK) ? lookup_idx : hit_idx_q;
    promote_mask = '0;
    for (int j = 0; j < int'(LENGTH); j++) begin
      promote_mask[j] = (j <= int'(mask_idx));
    end
  end

  // Next state and request latch
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = CHECK;
        end
      end
      CHECK: begin
        hit_d     = lookup_hit;
        hit_idx_d = lookup_idx;
        if (we_q)            state_d = MEM_WR;
        else if (lookup_hit) state_d = IDLE;
        else                 state_d = MEM_RD;
      end
      MEM_RD, MEM_WR: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; response, memory request and enables are suppressed during rst
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_hit   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    sr_en      = '0;
    sr_d       = '0;
    case (state_q)
      CHECK: begin
        if (!we_q && lookup_hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          resp_rdata = lookup_entry[DATA_W-1:0];
          sr_en      = promote_mask;
          sr_d       = lookup_entry;
        end
      end
      MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          resp_valid = 1'b1;
          resp_rdata = mem_rdata;
          sr_en      = '1;
          sr_d       = {1'b0, addr_q, mem_rdata};
        end
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          resp_valid = 1'b1;
          resp_hit   = hit_q;
          sr_en      = hit_q ? promote_mask : '1;
          sr_d       = {1'b0, addr_q, wdata_q};
        end
      end
      default: ;
    endcase
    if (rst) begin
      resp_valid = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      sr_en      = '0;
    end
  end

endmodule

// File: tb/tb_cache_lru_ctrl.sv
// Directed testbench for cache_lru_ctrl with a behavioural en_shift_reg model.
module tb_cache_lru_ctrl;

  localparam int unsigned LENGTH  = 8;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;

  logic                        clk;
  logic                        rst;
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [ADDR_W-1:0]           req_addr;
  logic [DATA_W-1:0]           req_wdata;
  logic                        resp_valid;
  logic [DATA_W-1:0]           resp_rdata;
  logic                        resp_hit;
  logic                        mem_req;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic                        mem_ack;
  logic [DATA_W-1:0]           mem_rdata;
  logic [LENGTH-1:0]           sr_en;
  logic [ENTRY_W-1:0]          sr_d;
  logic [LENGTH*ENTRY_W-1:0]   sr_q;

  int n_tests;
  int n_fail;

  // Captured transaction results
  logic               r_got, r_stable, r_ready, r_ack, r_hit, r_mwe;
  int                 r_lat, r_nreq;
  logic [DATA_W-1:0]  r_rdata, r_mwdata;
  logic [LENGTH-1:0]  r_sren;
  logic [ENTRY_W-1:0] r_srd;
  logic [ADDR_W-1:0]  r_maddr;

  cache_lru_ctrl #(.LENGTH(LENGTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .sr_en(sr_en), .sr_d(sr_d), .sr_q(sr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift register model: reset to all ones, entry j loads entry j-1, entry 0 loads D
  logic [ENTRY_W-1:0] sr_mem [LENGTH];
  always @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < LENGTH; j++) sr_mem[j] <= '1;
    end else begin
      if (sr_en[0]) sr_mem[0] <= sr_d;
      for (int j = 1; j < LENGTH; j++) if (sr_en[j]) sr_mem[j] <= sr_mem[j-1];
    end
  end
  always_comb begin
    for (int j = 0; j < LENGTH; j++) sr_q[ENTRY_W*j +: ENTRY_W] = sr_mem[j];
  end

  // Issue one request from a negedge; memory acks in the ack_delay-th mem_req cycle.
  task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int ack_delay,
                         input logic [DATA_W-1:0] ack_data);
    r_got = 1'b0; r_lat = 0; r_nreq = 0; r_stable = 1'b1; r_ack = 1'b0;
    r_hit = 1'b0; r_rdata = '0; r_sren = '0; r_srd = '0;
    r_mwe = 1'b0; r_maddr = '0; r_mwdata = '0;
    r_ready = req_ready;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    for (int cyc = 1; cyc <= 40 && !r_got; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (r_nreq == 0) begin
          r_mwe = mem_we; r_maddr = mem_addr; r_mwdata = mem_wdata;
        end else if (mem_we !== r_mwe || mem_addr !== r_maddr || mem_wdata !== r_mwdata) begin
          r_stable = 1'b0;
        end
        r_nreq++;
        if (r_nreq == ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = ack_data;
        end
      end
      #1;
      if (resp_valid) begin
        r_got = 1'b1; r_lat = cyc; r_ack = mem_ack;
        r_rdata = resp_rdata; r_hit = resp_hit; r_sren = sr_en; r_srd = sr_d;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    n_tests++; if (sr_en !== '0) begin n_fail++; $display("FAIL rst_sr_en_during: got %h want 00", sr_en); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req_during: got %b want 0", mem_req); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_tests++; if (sr_en !== '0) begin n_fail++; $display("FAIL rst_sr_en: got %h want 00", sr_en); end
    @(negedge clk);
  endtask

  task automatic test_read_miss;
    run_txn(1'b0, 16'h0010, 8'h00, 3, 8'hAB);
    n_tests++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL miss_ready: got %b want 1", r_ready); end
    n_tests++; if (r_got !== 1'b1) begin n_fail++; $display("FAIL miss_resp: got %b want 1", r_got); end
    n_tests++; if (r_nreq !== 3) begin n_fail++; $display("FAIL miss_mem_req_cycles: got %0d want 3", r_nreq); end
    n_tests++; if (r_ack !== 1'b1) begin n_fail++; $display("FAIL miss_resp_in_ack_cycle: got %b want 1", r_ack); end
    n_tests++; if (r_rdata !== 8'hAB) begin n_fail++; $display("FAIL miss_rdata: got %h want ab", r_rdata); end
    n_tests++; if (r_hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit: got %b want 0", r_hit); end
    n_tests++; if (r_sren !== 8'hFF) begin n_fail++; $display("FAIL miss_sr_en: got %h want ff", r_sren); end
    n_tests++; if (r_srd !== {1'b0, 16'h0010, 8'hAB}) begin n_fail++; $display("FAIL miss_sr_d: got %h want %h", r_srd, {1'b0, 16'h0010, 8'hAB}); end
    n_tests++; if (r_mwe !== 1'b0 || r_maddr !== 16'h0010) begin n_fail++; $display("FAIL miss_mem_cmd: got we=%b addr=%h want we=0 addr=0010", r_mwe, r_maddr); end
    n_tests++; if (r_stable !== 1'b1) begin n_fail++; $display("FAIL miss_mem_stable: got %b want 1", r_stable); end
  endtask

  task automatic test_read_hit;
    run_txn(1'b0, 16'h0010, 8'h00, 1, 8'hEE);
    n_tests++; if (r_nreq !== 0) begin n_fail++; $display("FAIL hit_mem_req_cycles: got %0d want 0", r_nreq); end
    n_tests++; if (r_lat !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d want 1", r_lat); end
    n_tests++; if (r_rdata !== 8'hAB) begin n_fail++; $display("FAIL hit_rdata: got %h want ab", r_rdata); end
    n_tests++; if (r_hit !== 1'b1) begin n_fail++; $display("FAIL hit_flag: got %b want 1", r_hit); end
    n_tests++; if (r_sren !== 8'h01) begin n_fail++; $display("FAIL hit_sr_en: got %h want 01", r_sren); end
    n_tests++; if (r_srd !== {1'b0, 16'h0010, 8'hAB}) begin n_fail++; $display("FAIL hit_sr_d: got %h want %h", r_srd, {1'b0, 16'h0010, 8'hAB}); end
  endtask

  task automatic test_lru_eviction;
    int fill_hits;
    int fill_reqs;
    fill_hits = 0; fill_reqs = 0;
    for (int i = 0; i < 8; i++) begin
      run_txn(1'b0, 16'h0100 + 16'(i), 8'h00, 1, 8'h10 + 8'(i));
      if (r_hit !== 1'b0 || r_got !== 1'b1) fill_hits++;
      fill_reqs += r_nreq;
    end
    n_tests++; if (fill_hits !== 0) begin n_fail++; $display("FAIL fill_hits: got %0d want 0", fill_hits); end
    n_tests++; if (fill_reqs !== 8) begin n_fail++; $display("FAIL fill_mem_reqs: got %0d want 8", fill_reqs); end
    // 0x0100 now sits at the LRU slot
    run_txn(1'b0, 16'h0100, 8'h00, 1, 8'hEE);
    n_tests++; if (r_hit !== 1'b1 || r_nreq !== 0) begin n_fail++; $display("FAIL lru_hit: got hit=%b reqs=%0d want hit=1 reqs=0", r_hit, r_nreq); end
    n_tests++; if (r_sren !== 8'hFF) begin n_fail++; $display("FAIL lru_hit_sr_en: got %h want ff", r_sren); end
    n_tests++; if (r_rdata !== 8'h10) begin n_fail++; $display("FAIL lru_hit_rdata: got %h want 10", r_rdata); end
    run_txn(1'b0, 16'h0108, 8'h00, 1, 8'h18);
    n_tests++; if (r_hit !== 1'b0 || r_nreq !== 1) begin n_fail++; $display("FAIL evict_miss: got hit=%b reqs=%0d want hit=0 reqs=1", r_hit, r_nreq); end
    // Order is now 0108,0100,0107,...,0102; 0x0101 was evicted
    run_txn(1'b0, 16'h0107, 8'h00, 1, 8'hEE);
    n_tests++; if (r_hit !== 1'b1 || r_sren !== 8'h07) begin n_fail++; $display("FAIL mid_hit: got hit=%b sr_en=%h want hit=1 sr_en=07", r_hit, r_sren); end
    run_txn(1'b0, 16'h0101, 8'h00, 1, 8'h11);
    n_tests++; if (r_hit !== 1'b0 || r_nreq !== 1) begin n_fail++; $display("FAIL evicted_entry: got hit=%b reqs=%0d want hit=0 reqs=1", r_hit, r_nreq); end
  endtask

  task automatic test_write;
    test_reset();
    run_txn(1'b0, 16'h0010, 8'h00, 1, 8'hAB);
    run_txn(1'b0, 16'h0020, 8'h00, 1, 8'h11);
    // 0x0010 now at index 1
    run_txn(1'b1, 16'h0010, 8'h5C, 2, 8'hEE);
    n_tests++; if (r_got !== 1'b1 || r_nreq !== 2 || r_ack !== 1'b1) begin n_fail++; $display("FAIL wr_hit_resp: got resp=%b reqs=%0d ack=%b want 1/2/1", r_got, r_nreq, r_ack); end
    n_tests++; if (r_mwe !== 1'b1 || r_maddr !== 16'h0010 || r_mwdata !== 8'h5C) begin n_fail++; $display("FAIL wr_mem_cmd: got we=%b addr=%h data=%h want 1/0010/5c", r_mwe, r_maddr, r_mwdata); end
    n_tests++; if (r_stable !== 1'b1) begin n_fail++; $display("FAIL wr_mem_stable: got %b want 1", r_stable); end
    n_tests++; if (r_hit !== 1'b1) begin n_fail++; $display("FAIL wr_hit_flag: got %b want 1", r_hit); end
    n_tests++; if (r_sren !== 8'h03) begin n_fail++; $display("FAIL wr_hit_sr_en: got %h want 03", r_sren); end
    n_tests++; if (r_srd !== {1'b0, 16'h0010, 8'h5C}) begin n_fail++; $display("FAIL wr_hit_sr_d: got %h want %h", r_srd, {1'b0, 16'h0010, 8'h5C}); end
    run_txn(1'b0, 16'h0010, 8'h00, 1, 8'hEE);
    n_tests++; if (r_hit !== 1'b1 || r_nreq !== 0 || r_rdata !== 8'h5C) begin n_fail++; $display("FAIL wr_readback: got hit=%b reqs=%0d data=%h want 1/0/5c", r_hit, r_nreq, r_rdata); end
    n_tests++; if (r_sren !== 8'h01) begin n_fail++; $display("FAIL wr_readback_sr_en: got %h want 01", r_sren); end
    run_txn(1'b0, 16'h0020, 8'h00, 1, 8'hEE);
    n_tests++; if (r_hit !== 1'b1 || r_rdata !== 8'h11 || r_sren !== 8'h03) begin n_fail++; $display("FAIL old_entry_hit: got hit=%b data=%h sr_en=%h want 1/11/03", r_hit, r_rdata, r_sren); end
    // Write miss allocates
    run_txn(1'b1, 16'h0030, 8'h77, 1, 8'hEE);
    n_tests++; if (r_hit !== 1'b0 || r_sren !== 8'hFF || r_nreq !== 1) begin n_fail++; $display("FAIL wr_miss: got hit=%b sr_en=%h reqs=%0d want 0/ff/1", r_hit, r_sren, r_nreq); end
    run_txn(1'b0, 16'h0030, 8'h00, 1, 8'hEE);
    n_tests++; if (r_hit !== 1'b1 || r_rdata !== 8'h77 || r_nreq !== 0) begin n_fail++; $display("FAIL wr_alloc_read: got hit=%b data=%h reqs=%0d want 1/77/0", r_hit, r_rdata, r_nreq); end
  endtask

  task automatic test_empty_no_match;
    test_reset();
    run_txn(1'b0, 16'hFFFF, 8'h00, 2, 8'h3C);
    n_tests++; if (r_hit !== 1'b0 || r_nreq !== 2) begin n_fail++; $display("FAIL empty_match: got hit=%b reqs=%0d want 0/2", r_hit, r_nreq); end
    n_tests++; if (r_rdata !== 8'h3C || r_maddr !== 16'hFFFF) begin n_fail++; $display("FAIL empty_miss_data: got data=%h addr=%h want 3c/ffff", r_rdata, r_maddr); end
    run_txn(1'b0, 16'hFFFF, 8'h00, 1, 8'hEE);
    n_tests++; if (r_hit !== 1'b1 || r_rdata !== 8'h3C) begin n_fail++; $display("FAIL ffff_hit: got hit=%b data=%h want 1/3c", r_hit, r_rdata); end
  endtask

  task automatic test_reset_mid;
    test_reset();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040; req_wdata = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_mem_req: got %b want 1", mem_req); end
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h99;
    #1;
    n_tests++; if (resp_valid !== 1'b0 || sr_en !== '0) begin n_fail++; $display("FAIL mid_rst_ack: got resp=%b sr_en=%h want 0/00", resp_valid, sr_en); end
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_after: got req=%b ready=%b resp=%b want 0/1/0", mem_req, req_ready, resp_valid); end
    // Stray ack in IDLE is ignored
    mem_ack = 1'b1;
    #1;
    n_tests++; if (resp_valid !== 1'b0 || sr_en !== '0) begin n_fail++; $display("FAIL stray_ack: got resp=%b sr_en=%h want 0/00", resp_valid, sr_en); end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL stray_ack_state: got ready=%b want 1", req_ready); end
    run_txn(1'b0, 16'h0040, 8'h00, 1, 8'h41);
    n_tests++; if (r_hit !== 1'b0 || r_nreq !== 1 || r_rdata !== 8'h41) begin n_fail++; $display("FAIL reread_after_rst: got hit=%b reqs=%0d data=%h want 0/1/41", r_hit, r_nreq, r_rdata); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_lru_eviction();
    test_write();
    test_empty_no_match();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
